// File: rtl/gtech_reduce_pipe.sv
// rtl/gtech_reduce_pipe.sv - pipelined N-input bitwise AND/OR/XOR reduction over a registered radix-4 tree
// Optional XOR/XNOR path is built when GTECH_REDUCE_XOR_EN is defined.
module gtech_reduce_pipe #(
  parameter int N = 5,
  parameter int W = 1
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           EN,
  input  logic           VI,
  input  logic [1:0]     OP,
  input  logic           INV,
  input  logic [N*W-1:0] A,
  output logic [W-1:0]   Z,
  output logic           VO,
  output logic           ERR
);
  localparam int L = (N <= 4) ? 1 : (N <= 16) ? 2 : 3;
  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
`ifdef GTECH_REDUCE_XOR_EN
  localparam logic [1:0] OP_XOR = 2'b10;
`endif

  function automatic int node_cnt(input int lvl);
    int c;
    c = N;
    for (int i = 0; i < lvl; i++) c = (c + 3) / 4;
    return c;
  endfunction

  function automatic logic [W-1:0] reduce4(input logic [1:0] op, input logic [3:0][W-1:0] v);
    logic [W-1:0] r;
    case (op)
      OP_OR:   r = v[0] | v[1] | v[2] | v[3];
`ifdef GTECH_REDUCE_XOR_EN
      OP_XOR:  r = v[0] ^ v[1] ^ v[2] ^ v[3];
`endif
      default: r = v[0] & v[1] & v[2] & v[3];
    endcase
    return r;
  endfunction

  logic [W-1:0] w_node [0:L][0:N-1];
  logic [1:0]   w_op   [0:L-1];
  logic         w_inv  [0:L-1];
  logic         w_vld  [0:L];
  logic         w_err  [0:L];

  // Unsupported codes are folded to AND at the input so the tree only sees legal functions.
`ifdef GTECH_REDUCE_XOR_EN
  assign w_op[0]  = (OP == 2'b11) ? OP_AND : OP;
  assign w_err[0] = (OP == 2'b11);
`else
  assign w_op[0]  = (OP == OP_OR) ? OP_OR : OP_AND;
  assign w_err[0] = OP[1];
`endif
  assign w_inv[0] = INV;
  assign w_vld[0] = VI;

  for (genvar k = 0; k < N; k++) begin : g_in
    assign w_node[0][k] = A[k*W +: W];
  end

  for (genvar gl = 1; gl <= L; gl++) begin : g_lvl
    localparam int CP = node_cnt(gl - 1);
    localparam int CN = node_cnt(gl);
    logic [W-1:0]      w_red  [0:CN-1];
    logic [W-1:0]      r_node [0:CN-1];
    logic              r_vld;
    logic              r_err;
    logic [3:0][W-1:0] w_grp;

    always_comb begin
      w_grp = '0;
      for (int g = 0; g < CN; g++) begin
        for (int j = 0; j < 4; j++) begin
          if (4*g + j < CP) w_grp[j] = w_node[gl-1][4*g + j];
          else              w_grp[j] = (w_op[gl-1] == OP_AND) ? '1 : '0;
        end
        w_red[g] = reduce4(w_op[gl-1], w_grp) ^ ((gl == L) ? {W{w_inv[gl-1]}} : '0);
      end
    end

    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        r_vld <= 1'b0;
        r_err <= 1'b0;
        for (int g = 0; g < CN; g++) r_node[g] <= '0;
      end else if (EN) begin
        r_vld <= w_vld[gl-1];
        r_err <= w_err[gl-1];
        for (int g = 0; g < CN; g++) r_node[g] <= w_red[g];
      end
    end

    assign w_vld[gl] = r_vld;
    assign w_err[gl] = r_err;

    for (genvar gn = 0; gn < N; gn++) begin : g_out
      if (gn < CN) begin : g_used
        assign w_node[gl][gn] = r_node[gn];
      end else begin : g_pad
        assign w_node[gl][gn] = '0;
      end
    end

    // The function and invert bits are consumed at the last level and need no register there.
    if (gl < L) begin : g_ctl
      logic [1:0] r_op;
      logic       r_inv;
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          r_op  <= 2'b00;
          r_inv <= 1'b0;
        end else if (EN) begin
          r_op  <= w_op[gl-1];
          r_inv <= w_inv[gl-1];
        end
      end
      assign w_op[gl]  = r_op;
      assign w_inv[gl] = r_inv;
    end
  end

  assign Z   = w_node[L][0];
  assign VO  = w_vld[L];
  assign ERR = w_err[L];
endmodule

// File: tb/tb_gtech_reduce_pipe.sv
// tb/tb_gtech_reduce_pipe.sv - scoreboard bench for gtech_reduce_pipe (N=5/W=1 and N=6/W=4 instances)
module tb_gtech_reduce_pipe;
  logic        clk = 1'b0;
  logic        RST;
  logic        EN;
  logic        VI;
  logic [1:0]  OP;
  logic        INV;
  logic [4:0]  A5;
  logic [23:0] A6;
  logic        Z5;
  logic [3:0]  Z6;
  logic        VO5, VO6, ERR5, ERR6;

  int n_checks = 0;
  int n_errors = 0;

  logic [4:0] q5[$];
  logic [4:0] q6[$];
  logic [1:0] mv;
  logic [4:0] last5, last6;

  always #5 clk = ~clk;

  gtech_reduce_pipe #(.N(5), .W(1)) u_dut5 (
    .CLK(clk), .RST(RST), .EN(EN), .VI(VI), .OP(OP), .INV(INV),
    .A(A5), .Z(Z5), .VO(VO5), .ERR(ERR5)
  );

  gtech_reduce_pipe #(.N(6), .W(4)) u_dut6 (
    .CLK(clk), .RST(RST), .EN(EN), .VI(VI), .OP(OP), .INV(INV),
    .A(A6), .Z(Z6), .VO(VO6), .ERR(ERR6)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Flat reference reduction; returns {err, z[3:0]}.
  function automatic logic [4:0] exp_out(input int n, input int w, input logic [23:0] a,
                                         input logic [1:0] op, input logic inv);
    logic [3:0]  acc, mask, v;
    logic [23:0] t;
    logic        err;
    logic [1:0]  eop;
    mask = (w == 4) ? 4'hF : 4'h1;
`ifdef GTECH_REDUCE_XOR_EN
    err = (op == 2'b11);
    eop = err ? 2'b00 : op;
`else
    err = op[1];
    eop = op[1] ? 2'b00 : op;
`endif
    acc = (eop == 2'b00) ? 4'hF : 4'h0;
    for (int k = 0; k < n; k++) begin
      t = a >> (k * w);
      v = t[3:0] & mask;
      case (eop)
        2'b01:   acc = acc | v;
        2'b10:   acc = acc ^ v;
        default: acc = acc & v;
      endcase
    end
    acc = (acc ^ {4{inv}}) & mask;
    return {err, acc};
  endfunction

  task automatic cycle(input logic [4:0] a5, input logic [23:0] a6, input logic [1:0] op,
                       input logic inv, input logic vi, input logic en);
    logic [4:0] e;
    A5 = a5; A6 = a6; OP = op; INV = inv; VI = vi; EN = en;
    if (en) begin
      if (vi) begin
        q5.push_back(exp_out(5, 1, {19'b0, a5}, op, inv));
        q6.push_back(exp_out(6, 4, a6, op, inv));
      end
      mv = {mv[0], vi};
    end
    @(posedge clk);
    #1;
    check_val("vo5", VO5, mv[1]);
    check_val("vo6", VO6, mv[1]);
    check_val("z5_known", $isunknown(Z5), 0);
    check_val("z6_known", $isunknown(Z6), 0);
    if (en) begin
      if (VO5) begin
        if (q5.size() == 0) check_val("q5_underflow", 1, 0);
        else begin
          e = q5.pop_front(); last5 = e;
          check_val("z5", Z5, e[0]);
          check_val("err5", ERR5, e[4]);
        end
      end
      if (VO6) begin
        if (q6.size() == 0) check_val("q6_underflow", 1, 0);
        else begin
          e = q6.pop_front(); last6 = e;
          check_val("z6", Z6, e[3:0]);
          check_val("err6", ERR6, e[4]);
        end
      end
    end else if (mv[1]) begin
      check_val("stall_z5", Z5, last5[0]);
      check_val("stall_err5", ERR5, last5[4]);
      check_val("stall_z6", Z6, last6[3:0]);
      check_val("stall_err6", ERR6, last6[4]);
    end
  endtask

  initial begin
    mv = 2'b00; last5 = '0; last6 = '0;
    RST = 1'b1; EN = 1'b0; VI = 1'b0; OP = 2'b00; INV = 1'b0; A5 = '0; A6 = '0;
    @(posedge clk); @(posedge clk); #1;
    check_val("rst_vo5", VO5, 0);  check_val("rst_z5", Z5, 0);  check_val("rst_err5", ERR5, 0);
    check_val("rst_vo6", VO6, 0);  check_val("rst_z6", Z6, 0);  check_val("rst_err6", ERR6, 0);
    RST = 1'b0;

    // NAND of all ones, then NAND with one zero operand
    cycle(5'b11111, 24'hFFFFFF, 2'b00, 1'b1, 1'b1, 1'b1);
    cycle(5'b00000, 24'h000000, 2'b00, 1'b0, 1'b0, 1'b1);
    cycle(5'b00000, 24'h000000, 2'b00, 1'b0, 1'b0, 1'b1);
    cycle(5'b11110, 24'hFFFFF0, 2'b00, 1'b1, 1'b1, 1'b1);
    cycle(5'b00000, 24'h000000, 2'b00, 1'b0, 1'b0, 1'b1);
    cycle(5'b00000, 24'h000000, 2'b00, 1'b0, 1'b0, 1'b1);

    // back-to-back per-sample function tracking, with padding patterns on the N=6 instance
    cycle(5'b11111, 24'hFFFFFF, 2'b00, 1'b0, 1'b1, 1'b1);
    cycle(5'b00000, 24'h800000, 2'b01, 1'b0, 1'b1, 1'b1);
    cycle(5'b10110, 24'h5A3C96, 2'b10, 1'b0, 1'b1, 1'b1);
    cycle(5'b10110, 24'h5A3C96, 2'b10, 1'b1, 1'b1, 1'b1);
    cycle(5'b00000, 24'h000000, 2'b00, 1'b0, 1'b0, 1'b1);
    cycle(5'b00000, 24'h000000, 2'b00, 1'b0, 1'b0, 1'b1);

    // reserved OP code
    cycle(5'b11111, 24'hFFFFFF, 2'b11, 1'b0, 1'b1, 1'b1);
    cycle(5'b00000, 24'h000000, 2'b00, 1'b0, 1'b0, 1'b1);
    cycle(5'b00000, 24'h000000, 2'b00, 1'b0, 1'b0, 1'b1);

    // stall with one result at the output and one at level 1; stalled inputs must not be captured
    cycle(5'b01000, 24'h000700, 2'b01, 1'b0, 1'b1, 1'b1);
    cycle(5'b11111, 24'hF0FFFF, 2'b00, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) cycle(5'b10101, 24'h123456, 2'b01, 1'b0, 1'b1, 1'b0);
    cycle(5'b00000, 24'h000000, 2'b00, 1'b0, 1'b0, 1'b1);
    cycle(5'b00000, 24'h000000, 2'b00, 1'b0, 1'b0, 1'b1);

    // random mix including random stalls
    for (int i = 0; i < 40; i++)
      cycle(5'($urandom), 24'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) != 0));

    // asynchronous reset between edges with samples in flight
    cycle(5'b11111, 24'hFFFFFF, 2'b11, 1'b1, 1'b1, 1'b1);
    cycle(5'b11111, 24'hFFFFFF, 2'b11, 1'b0, 1'b1, 1'b1);
    cycle(5'b11111, 24'hFFFFFF, 2'b11, 1'b0, 1'b1, 1'b1);
    #2;
    RST = 1'b1;
    #1;
    check_val("mid_rst_vo5", VO5, 0);  check_val("mid_rst_z5", Z5, 0);  check_val("mid_rst_err5", ERR5, 0);
    check_val("mid_rst_vo6", VO6, 0);  check_val("mid_rst_z6", Z6, 0);  check_val("mid_rst_err6", ERR6, 0);
    q5.delete(); q6.delete(); mv = 2'b00;
    EN = 1'b1;
    @(posedge clk); #1;
    RST = 1'b0;
    for (int i = 0; i < 4; i++) cycle(5'b11111, 24'hFFFFFF, 2'b00, 1'b0, 1'b0, 1'b1);

    check_val("q5_drained", q5.size(), 0);
    check_val("q6_drained", q6.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
